// File: rtl/raizing_pkg.sv
// Shared definitions for the Raizing extra-text layer: writer FSM states,
// region encoding and constants also used by the renderer.
package raizing_pkg;

  // Stored scroll values are raw; the renderer adds this bias.
  localparam logic [5:0] EXTRATEXT_SCROLL_BIAS = 6'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RDWAIT,
    ST_ACK,
    ST_CLEAR
  } wr_state_e;

  typedef enum logic [1:0] {
    REG_VRAM,
    REG_SELECT,
    REG_SCROLL
  } region_e;

  // VRAM beats select beats scroll when the decoder raises several selects.
  function automatic region_e region_decode(input logic vram_cs,
                                            input logic select_cs,
                                            input logic scroll_cs);
    if (vram_cs)        return REG_VRAM;
    else if (select_cs) return REG_SELECT;
    else if (scroll_cs) return REG_SCROLL;
    else                return REG_SCROLL;
  endfunction

endpackage

// File: rtl/raizing_extratext_clr.sv
// Text VRAM zero-fill engine: pending-request latch plus a sweep counter that
// walks 0..VRAM_WORDS-1 once per start and stops on the last word.
module raizing_extratext_clr #(
  parameter int VRAM_WORDS = 4096,
  parameter int ADDR_W     = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear_req,
  input  logic              start,
  output logic              pend,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_WORDS - 1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend <= 1'b0;
      busy <= 1'b0;
      addr <= '0;
    end else begin
      // A request arriving while a sweep runs re-arms for one more sweep.
      if (clear_req)  pend <= 1'b1;
      else if (start) pend <= 1'b0;

      if (start) begin
        busy <= 1'b1;
        addr <= '0;
      end else if (busy) begin
        if (addr == LAST_ADDR) busy <= 1'b0;
        else                   addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign done = busy && (addr == LAST_ADDR);

endmodule

// File: rtl/raizing_extratext_wr.sv
// CPU-side writer for the Raizing extra-text layer: 68000 bus slave in front of
// the text VRAM, line-select and line-scroll RAMs, with a VRAM clear engine.
module raizing_extratext_wr
  import raizing_pkg::*;
#(
  parameter int READ_LAT   = 2,
  parameter int VRAM_WORDS = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] CPU_ADDR,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  input  logic        CPU_RW,
  input  logic        CPU_AS_N,
  input  logic        CPU_UDS_N,
  input  logic        CPU_LDS_N,
  input  logic        TEXTVRAM_CS,
  input  logic        TEXTSELECT_CS,
  input  logic        TEXTSCROLL_CS,
  output logic        DTACK_N,
  input  logic        CLEAR_REQ,
  output logic        BUSY,
  output logic [11:0] TEXTVRAM_WADDR,
  output logic [15:0] TEXTVRAM_WDATA,
  output logic [1:0]  TEXTVRAM_WE,
  input  logic [15:0] TEXTVRAM_RDATA,
  output logic [7:0]  TEXTSELECT_WADDR,
  output logic [15:0] TEXTSELECT_WDATA,
  output logic [1:0]  TEXTSELECT_WE,
  input  logic [15:0] TEXTSELECT_RDATA,
  output logic [7:0]  TEXTSCROLL_WADDR,
  output logic [15:0] TEXTSCROLL_WDATA,
  output logic [1:0]  TEXTSCROLL_WE,
  input  logic [15:0] TEXTSCROLL_RDATA
);

  localparam int CNT_W = $clog2(READ_LAT + 1) + 1;

  wr_state_e         state;
  region_e           region;
  logic              armed;
  logic [CNT_W-1:0]  rd_cnt;
  logic [11:0]       vram_waddr;
  logic [15:0]       vram_wdata;
  logic [1:0]        vram_we;
  logic [15:0]       rdata_sel;

  logic              clr_pend;
  logic              clr_busy;
  logic              clr_done;
  logic              clr_start;
  logic [11:0]       sweep_addr;

  // Upper address bits are decoded upstream into the CS lines.
  logic unused_addr_bits;
  assign unused_addr_bits = ^CPU_ADDR[23:13];

  logic    access_req;
  logic [1:0] wr_be;
  region_e req_region;

  assign access_req = !CPU_AS_N && (!CPU_UDS_N || !CPU_LDS_N) && armed &&
                      (TEXTVRAM_CS || TEXTSELECT_CS || TEXTSCROLL_CS);
  assign wr_be      = CPU_RW ? 2'b00 : {!CPU_UDS_N, !CPU_LDS_N};
  assign req_region = region_decode(TEXTVRAM_CS, TEXTSELECT_CS, TEXTSCROLL_CS);
  assign clr_start  = (state == ST_IDLE) && !access_req && clr_pend;

  // NOTE: combinational blocks assign a default first so no path can
  // leave the output unassigned and infer a latch.
  always_comb begin
    rdata_sel = TEXTSCROLL_RDATA;
    unique case (region)
      REG_VRAM:   rdata_sel = TEXTVRAM_RDATA;
      REG_SELECT: rdata_sel = TEXTSELECT_RDATA;
      default:    rdata_sel = TEXTSCROLL_RDATA;
    endcase
  end

  raizing_extratext_clr #(
    .VRAM_WORDS (VRAM_WORDS),
    .ADDR_W     (12)
  ) u_clr (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear_req (CLEAR_REQ),
    .start     (clr_start),
    .pend      (clr_pend),
    .busy      (clr_busy),
    .addr      (sweep_addr),
    .done      (clr_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= ST_IDLE;
      region           <= REG_VRAM;
      armed            <= 1'b1;
      rd_cnt           <= '0;
      DTACK_N          <= 1'b1;
      CPU_DOUT         <= '0;
      vram_waddr       <= '0;
      vram_wdata       <= '0;
      vram_we          <= '0;
      TEXTSELECT_WADDR <= '0;
      TEXTSELECT_WDATA <= '0;
      TEXTSELECT_WE    <= '0;
      TEXTSCROLL_WADDR <= '0;
      TEXTSCROLL_WDATA <= '0;
      TEXTSCROLL_WE    <= '0;
    end else begin
      if (CPU_AS_N) armed <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          // A CPU access takes precedence over a pending clear.
          if (access_req) begin
            armed  <= 1'b0;
            region <= req_region;
            rd_cnt <= '0;
            state  <= CPU_RW ? ST_RDWAIT : ST_WRITE;
            unique case (req_region)
              REG_VRAM: begin
                vram_waddr <= CPU_ADDR[12:1];
                vram_wdata <= CPU_DIN;
                vram_we    <= wr_be;
              end
              REG_SELECT: begin
                TEXTSELECT_WADDR <= CPU_ADDR[8:1];
                TEXTSELECT_WDATA <= CPU_DIN;
                TEXTSELECT_WE    <= wr_be;
              end
              default: begin
                TEXTSCROLL_WADDR <= CPU_ADDR[8:1];
                TEXTSCROLL_WDATA <= CPU_DIN;
                TEXTSCROLL_WE    <= wr_be;
              end
            endcase
          end else if (clr_pend) begin
            state <= ST_CLEAR;
          end
        end

        ST_WRITE: begin
          vram_we       <= '0;
          TEXTSELECT_WE <= '0;
          TEXTSCROLL_WE <= '0;
          DTACK_N       <= 1'b0;
          state         <= ST_ACK;
        end

        ST_RDWAIT: begin
          if (rd_cnt == CNT_W'(READ_LAT)) begin
            CPU_DOUT <= rdata_sel;
            DTACK_N  <= 1'b0;
            state    <= ST_ACK;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end

        ST_ACK: begin
          if (CPU_AS_N) begin
            DTACK_N <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        ST_CLEAR: begin
          if (clr_done) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // The sweep owns the VRAM write port for the whole clear.
  assign TEXTVRAM_WADDR = clr_busy ? sweep_addr : vram_waddr;
  assign TEXTVRAM_WDATA = clr_busy ? 16'h0000   : vram_wdata;
  assign TEXTVRAM_WE    = clr_busy ? 2'b11      : vram_we;
  assign BUSY           = clr_busy;

endmodule

// File: doc/raizing_extratext_wr.md
# raizing_extratext_wr

CPU-side writer for the Raizing extra-text layer: 68000 bus slave that writes and reads back the text VRAM, line-select RAM and line-scroll RAM that the extra-text renderer consumes through their video ports. Sits between the main-CPU address decoder and the CPU ports of the three dual-port RAMs. Adds a hardware clear engine that zero-fills text VRAM on request. Generates DTACK for every access.

## Interface
- `READ_LAT`, 2: RAM read latency in clocks, address to data; matches the renderer-side RAMs.
- `VRAM_WORDS`, 4096: text VRAM depth in 16-bit words; the clear engine sweeps 0..`VRAM_WORDS`-1.
- `CLK` in 1: system clock, CPU domain; all strobes are already synchronous to it.
- `RESET` in 1: synchronous, active-high.
- `CPU_ADDR` in 23: word address A[23:1].
- `CPU_DIN` in 16: write data from CPU.
- `CPU_DOUT` out 16: read-back data, held until next read.
- `CPU_RW` in 1: 1 = read, 0 = write.
- `CPU_AS_N`, `CPU_UDS_N`, `CPU_LDS_N` in 1 each: address/data strobes, active low.
- `TEXTVRAM_CS`, `TEXTSELECT_CS`, `TEXTSCROLL_CS` in 1 each: decoded region selects, active high.
- `DTACK_N` out 1: transfer acknowledge, active low.
- `CLEAR_REQ` in 1: one-cycle pulse requesting VRAM zero-fill.
- `BUSY` out 1: high while the clear engine runs.
- `TEXTVRAM_WADDR` out 12, `TEXTVRAM_WDATA` out 16, `TEXTVRAM_WE` out 2 ([1]=upper byte), `TEXTVRAM_RDATA` in 16.
- `TEXTSELECT_WADDR` out 8, `TEXTSELECT_WDATA` out 16, `TEXTSELECT_WE` out 2, `TEXTSELECT_RDATA` in 16.
- `TEXTSCROLL_WADDR` out 8, `TEXTSCROLL_WDATA` out 16, `TEXTSCROLL_WE` out 2, `TEXTSCROLL_RDATA` in 16.

## Operation
- Access request: `!CPU_AS_N && (!CPU_UDS_N || !CPU_LDS_N) && any CS && armed`. `armed` is set on reset and whenever `CPU_AS_N` is sampled high; it clears on access start, so one bus cycle never produces two accesses.
- Region priority when several CS are high: VRAM > select > scroll. Address mapping: VRAM `CPU_ADDR[12:1]`, select/scroll `CPU_ADDR[8:1]`. Data stored raw; the renderer applies the scroll bias (+0x2C).
- Byte enables: `WE = {!CPU_UDS_N, !CPU_LDS_N}`, qualified by write. `WDATA = CPU_DIN`.
- FSM states: IDLE, WRITE, RDWAIT, ACK, CLEAR.
  - IDLE: CPU request wins over pending clear. Write -> WRITE. Read -> RDWAIT with the address driven. Pending clear with no request -> CLEAR.
  - WRITE: WE asserted exactly one cycle, then ACK.
  - RDWAIT: counts `READ_LAT` cycles, latches the selected `*_RDATA` into `CPU_DOUT`, then ACK.
  - ACK: `DTACK_N`=0 until `CPU_AS_N` sampled high, then `DTACK_N`=1 and -> IDLE.
  - CLEAR: `TEXTVRAM_WE`=2'b11, `WDATA`=0, address increments by 1 per cycle from 0 to `VRAM_WORDS`-1, then -> IDLE. CPU requests arriving during CLEAR are held (no DTACK) and serviced after it ends.
- `CLEAR_REQ` is latched into `clr_pend` in any state. It clears when CLEAR is entered. A `CLEAR_REQ` during CLEAR re-arms `clr_pend`, giving one further sweep.
- WE outputs are 0 in every state except WRITE and CLEAR.

## Timing
- Reset values: `DTACK_N`=1, `CPU_DOUT`=0, `BUSY`=0, all `*_WE`=0, all `*_WADDR`/`*_WDATA`=0, state IDLE, `clr_pend`=0, `armed`=1.
- Reset mid-CLEAR or mid-access: abort, outputs to reset values next edge, pending clear dropped.
- Write latency: request sampled at edge n -> WE high n+1 -> `DTACK_N` low n+2.
- Read latency: request at n -> `DTACK_N` low at n+2+`READ_LAT`, with `CPU_DOUT` valid in the same cycle.
- Clear: `BUSY` high from CLEAR entry for exactly `VRAM_WORDS` cycles. The last write is at address `VRAM_WORDS`-1; the address counter does not wrap to 0.
- `DTACK_N` deasserts one cycle after `CPU_AS_N` is sampled high.

## Structure
- Shared package `raizing_pkg`: FSM state enum, region-select encoding, `EXTRATEXT_SCROLL_BIAS`=6'h2C (shared with the renderer).
- One natural sub-module: `raizing_extratext_clr`, the sweep counter plus `clr_pend` latch with start/done handshake. The rest stays flat.

## Test plan
- Word write: VRAM CS, addr word 0x123, both strobes, din 0xBEEF -> `TEXTVRAM_WADDR`=0x123, `WE`=2'b11 for one cycle, `DTACK_N` low 2 cycles after request.
- Byte write: select CS, addr 0x10, only `CPU_LDS_N` low, din 0x12AB -> `TEXTSELECT_WE`=2'b01, `WADDR`=0x10.
- Read-back: scroll CS, addr 0xEF, `RDATA`=0x0155 -> `CPU_DOUT`=0x0155 with `DTACK_N` low 4 cycles after request; `DTACK_N` high one cycle after `AS_N` rises.
- Held strobes: `AS_N` held low for 20 cycles -> exactly one WE pulse.
- Clear collision: `CLEAR_REQ` pulse, VRAM write request at cycle 100 -> `BUSY` high for 4096 cycles, write completes afterwards, last clear address 0xFFF.
- Reset mid-clear: `RESET` at sweep address 0x400 -> next cycle `BUSY`=0, `WE`=0, `DTACK_N`=1, no further writes.
